bsg_front_side_bus_hop_out: RTL and testbench
=============================================

// Module: bsg_front_side_bus_hop_out
// PURPOSE
//  Fan-in counterpart of the FSB hop_in broadcaster. Merges fan_in_p ready/valid
//  sources (node-local and upstream) onto one FSB output channel. Arbitration is
//  round-robin; each accepted word passes through a 2-entry output buffer and
//  carries the index of its source. Sits at each FSB hop on the return path to the host.
// PARAMETERS
//  fan_in_p  5   number of input channels (>=2)
//  width_p   16  data word width in bits
//  lg_fan_in_lp  derived: $clog2(fan_in_p); width of src_o and the rr pointer
// PORTS
//  clk_i    in   1                   single clock; all state updates on posedge
//  reset_i  in   1                   asynchronous, active-high reset
//  v_i      in   fan_in_p            per-source valid
//  data_i   in   fan_in_p*width_p    source k word at [k*width_p +: width_p]
//  ready_o  out  fan_in_p            one-hot grant; word k accepted when v_i[k]&ready_o[k]
//  v_o      out  1                   output word valid
//  data_o   out  width_p             output word (don't-care when v_o=0)
//  src_o    out  lg_fan_in_lp        source index of data_o
//  ready_i  in   1                   downstream ready; word leaves when v_o&ready_i
// BEHAVIOUR
//  - Reset (async assert, sync release): buffer empty, full=0, head=tail=0, rr
//    pointer last_r = fan_in_p-1 (so source 0 has first priority). v_o=0, and
//    ready_o=0 while reset_i is high. Buffer storage is not reset.
//  - Buffer: 2 entries of {src, data}. space = ~full_r (registered; no
//    combinational ready_i->ready_o path). Enqueue only when space=1.
//  - Arbiter: when space=1, grant the first k with v_i[k]=1 scanning
//    last_r+1, last_r+2, ... modulo fan_in_p; ready_o = that one-hot grant, else 0.
//    ready_o[k] never asserts without v_i[k].
//  - last_r updates to the granted index only on an accepted transfer; unchanged otherwise.
//  - Latency: word accepted at edge t is visible on v_o/data_o/src_o after edge t
//    (1 cycle) if the buffer was empty; FIFO order is preserved.
//  - Throughput: 1 word/cycle sustained when ready_i=1 continuously.
//  - Full and ready_i=1: dequeue occurs, no enqueue that cycle (space is
//    registered); next cycle space=1.
//  - Empty with enqueue: v_o rises next cycle; no bypass of the buffer.
//  - Simultaneous enq/deq with one entry: occupancy stays 1, head and tail both advance.
//  - v_o/data_o/src_o are held stable while v_o=1 and ready_i=0.
//  - Mid-operation reset: buffered words are discarded; no partial transfer.
//  - Pointer wrap: head/tail are 1-bit and toggle; last_r wraps fan_in_p-1 -> 0.
// STRUCTURE
//  - Package bsg_fsb_pkg: fan-in/width defaults; struct {src, data} for buffer entries.
//  - Sub-module bsg_fsb_rr_arb (fan_in_p): inputs reqs, en, accept; outputs
//    one-hot grant and encoded index; owns last_r.
//  - Top: arbiter + data/src mux + 2-entry buffer (head/tail/full/empty regs).
// TESTING
//  1 Reset: assert reset_i mid-cycle with v_i=5'b11111 -> v_o=0, ready_o=0
//    immediately; after release, first grant = ready_o=5'b00001.
//  2 Round robin: v_i=5'b11111, ready_i=1, data k=16'hA000+k for 10 cycles ->
//    src_o sequence 0,1,2,3,4,0,1,2,3,4; data_o matches; one word/cycle after 1-cycle latency.
//  3 Backpressure: ready_i=0, v_i=5'b00100 -> 2 words accepted, then ready_o=0;
//    v_o/data_o hold; raise ready_i -> both drain in order, ready_o[2] reasserts one cycle after the first dequeue.
//  4 Sparse reqs: last grant 3, v_i=5'b00011 -> grant 0 then 1; v_i=5'b10010
//    after grant 1 -> grant 4 then 1.
//  5 No grant when idle: v_i=0 for 4 cycles -> ready_o=0, last_r unchanged,
//    v_o=0 once the buffer drains.
//  6 Random: random v_i/ready_i for 10k cycles vs scoreboard model -> no loss,
//    duplication or reorder per source; round-robin fairness (max wait < fan_in_p grants).

Source files
------------

// File: rtl/bsg_fsb_pkg.sv
// Shared defaults, buffer-entry layout and round-robin helper for the FSB hop blocks.
package bsg_fsb_pkg;

    localparam int unsigned FSB_FAN_IN_DEFAULT    = 5;
    localparam int unsigned FSB_WIDTH_DEFAULT     = 16;
    localparam int unsigned FSB_LG_FAN_IN_DEFAULT = $clog2(FSB_FAN_IN_DEFAULT);

    // Buffer entry for the default configuration; the top redeclares it per parameter set.
    typedef struct packed {
        logic [FSB_LG_FAN_IN_DEFAULT-1:0] src;
        logic [FSB_WIDTH_DEFAULT-1:0]     data;
    } fsb_entry_t;

    function automatic int unsigned fsb_rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bsg_fsb_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last accepted index.
module bsg_fsb_rr_arb
    import bsg_fsb_pkg::*;
#(
    parameter int unsigned fan_in_p = FSB_FAN_IN_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [fan_in_p-1:0]         reqs_i,
    input  logic                        en_i,
    input  logic                        accept_i,
    output logic [fan_in_p-1:0]         grant_o,
    output logic [$clog2(fan_in_p)-1:0] idx_o
);

    localparam int unsigned lg_fan_in_lp = $clog2(fan_in_p);

    logic [lg_fan_in_lp-1:0] r_last;
    logic [fan_in_p-1:0]     w_grant;
    logic [lg_fan_in_lp-1:0] w_idx;
    logic                    w_found;
    int unsigned             w_scan;

    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_scan  = 32'(r_last);
        for (int unsigned i = 0; i < fan_in_p; i++) begin
            w_scan = fsb_rr_next(w_scan, fan_in_p);
            if (!w_found && reqs_i[w_scan]) begin
                w_found         = 1'b1;
                w_grant[w_scan] = 1'b1;
                w_idx           = w_scan[lg_fan_in_lp-1:0];
            end
        end
        if (!en_i) begin
            w_grant = '0;
        end
    end

    assign grant_o = w_grant;
    assign idx_o   = w_idx;

    // Reset to the last index so source 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_last <= lg_fan_in_lp'(fan_in_p - 1);
        end else if (accept_i) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/bsg_front_side_bus_hop_out.sv
// FSB hop fan-in: round-robin merge of fan_in_p ready/valid sources into a 2-entry output buffer.
module bsg_front_side_bus_hop_out
    import bsg_fsb_pkg::*;
#(
    parameter int unsigned fan_in_p = FSB_FAN_IN_DEFAULT,
    parameter int unsigned width_p  = FSB_WIDTH_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [fan_in_p-1:0]           v_i,
    input  logic [fan_in_p*width_p-1:0]   data_i,
    output logic [fan_in_p-1:0]           ready_o,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    output logic [$clog2(fan_in_p)-1:0]   src_o,
    input  logic                          ready_i
);

    localparam int unsigned lg_fan_in_lp = $clog2(fan_in_p);

    typedef struct packed {
        logic [lg_fan_in_lp-1:0] src;
        logic [width_p-1:0]      data;
    } hop_entry_t;

    logic                    r_head;
    logic                    r_tail;
    logic                    r_full;
    logic                    r_empty;
    hop_entry_t              r_mem [2];

    logic                    w_space;
    logic [fan_in_p-1:0]     w_grant;
    logic [lg_fan_in_lp-1:0] w_idx;
    logic                    w_enq;
    logic                    w_deq;
    hop_entry_t              w_wr_entry;
    hop_entry_t              w_head_entry;

    // Space comes only from registered state, so ready_i never reaches ready_o.
    assign w_space = ~r_full & ~reset_i;

    bsg_fsb_rr_arb #(
        .fan_in_p(fan_in_p)
    ) u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .reqs_i  (v_i),
        .en_i    (w_space),
        .accept_i(w_enq),
        .grant_o (w_grant),
        .idx_o   (w_idx)
    );

    assign w_enq          = |w_grant;
    assign w_deq          = ~r_empty & ready_i;
    assign w_wr_entry.src  = w_idx;
    assign w_wr_entry.data = data_i[w_idx*width_p +: width_p];

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_tail] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_enq) begin
                r_tail <= ~r_tail;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            if (w_enq && !w_deq) begin
                r_empty <= 1'b0;
                r_full  <= ~r_empty;
            end else if (w_deq && !w_enq) begin
                r_full  <= 1'b0;
                r_empty <= ~r_full;
            end
        end
    end

    assign w_head_entry = r_mem[r_head];
    assign ready_o      = w_grant;
    assign v_o          = ~r_empty;
    assign data_o       = w_head_entry.data;
    assign src_o        = w_head_entry.src;

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out.sv
// Directed table plus scoreboard-checked random traffic for the FSB hop_out merger.
module tb_bsg_front_side_bus_hop_out;

    localparam int unsigned N = 5;
    localparam int unsigned W = 16;
    localparam int unsigned NV = 31;

    logic           clk;
    logic           reset_i;
    logic [N-1:0]   v_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   ready_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [2:0]     src_o;
    logic           ready_i;

    bsg_front_side_bus_hop_out #(
        .fan_in_p(N),
        .width_p (W)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .v_i    (v_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .v_o    (v_o),
        .data_o (data_o),
        .src_o  (src_o),
        .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic [W-1:0] base;
        logic [N-1:0] exp_ready;
        logic         exp_v;
        logic [2:0]   exp_src;
        logic [W-1:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [2:0]   src;
        logic [W-1:0] data;
    } word_t;

    vec_t  tbl [NV];
    word_t sb_q [$];
    int unsigned n_checks;
    int unsigned n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_base(input logic [W-1:0] base);
        for (int unsigned k = 0; k < N; k++) begin
            data_i[k*W +: W] = base + W'(k);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Round robin from reset, all sources requesting.
        for (int i = 0; i < 10; i++) begin
            tbl[i] = '{5'b11111, 1'b1, 16'hA000, N'(1 << (i % 5)), (i > 0),
                       3'((i + 4) % 5), 16'hA000 + 16'((i + 4) % 5)};
        end
        tbl[10] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b1, 3'd4, 16'hA004};
        // Backpressure with a single requester.
        tbl[11] = '{5'b00100, 1'b0, 16'hB000, 5'b00100, 1'b0, 3'd0, 16'h0000};
        tbl[12] = '{5'b00100, 1'b0, 16'hC000, 5'b00100, 1'b1, 3'd2, 16'hB002};
        tbl[13] = '{5'b00100, 1'b0, 16'hD000, 5'b00000, 1'b1, 3'd2, 16'hB002};
        tbl[14] = '{5'b00100, 1'b0, 16'hD000, 5'b00000, 1'b1, 3'd2, 16'hB002};
        tbl[15] = '{5'b00100, 1'b1, 16'hD000, 5'b00000, 1'b1, 3'd2, 16'hB002};
        tbl[16] = '{5'b00100, 1'b1, 16'hE000, 5'b00100, 1'b1, 3'd2, 16'hC002};
        tbl[17] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b1, 3'd2, 16'hE002};
        tbl[18] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b0, 3'd0, 16'h0000};
        // Sparse requests.
        tbl[19] = '{5'b01000, 1'b1, 16'hA000, 5'b01000, 1'b0, 3'd0, 16'h0000};
        tbl[20] = '{5'b00011, 1'b1, 16'hA000, 5'b00001, 1'b1, 3'd3, 16'hA003};
        tbl[21] = '{5'b00011, 1'b1, 16'hA000, 5'b00010, 1'b1, 3'd0, 16'hA000};
        tbl[22] = '{5'b10010, 1'b1, 16'hA000, 5'b10000, 1'b1, 3'd1, 16'hA001};
        tbl[23] = '{5'b10010, 1'b1, 16'hA000, 5'b00010, 1'b1, 3'd4, 16'hA004};
        // Idle: no grants, pointer held at 1.
        tbl[24] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b1, 3'd1, 16'hA001};
        tbl[25] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b0, 3'd0, 16'h0000};
        tbl[26] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b0, 3'd0, 16'h0000};
        tbl[27] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b0, 3'd0, 16'h0000};
        tbl[28] = '{5'b11111, 1'b1, 16'hA000, 5'b00100, 1'b0, 3'd0, 16'h0000};
        tbl[29] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b1, 3'd2, 16'hA002};
        tbl[30] = '{5'b00000, 1'b1, 16'hA000, 5'b00000, 1'b0, 3'd0, 16'h0000};

        reset_i = 1'b1;
        v_i     = '0;
        ready_i = 1'b0;
        drive_base(16'hA000);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        // Fill the buffer, then reset mid-cycle with all sources requesting.
        v_i = 5'b11111;
        repeat (3) @(negedge clk);
        #1;
        chk("prefill_v_o", 32'(v_o), 32'd1);
        chk("prefill_ready_full", 32'(ready_o), 32'd0);
        #1 reset_i = 1'b1;
        #1;
        chk("reset_v_o", 32'(v_o), 32'd0);
        chk("reset_ready_o", 32'(ready_o), 32'd0);
        @(negedge clk);
        #1;
        chk("reset_hold_ready_o", 32'(ready_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;

        for (int unsigned i = 0; i < NV; i++) begin
            v_i     = tbl[i].v;
            ready_i = tbl[i].rdy;
            drive_base(tbl[i].base);
            #1;
            chk($sformatf("vec%0d_ready_o", i), 32'(ready_o), 32'(tbl[i].exp_ready));
            chk($sformatf("vec%0d_v_o", i), 32'(v_o), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk($sformatf("vec%0d_src_o", i), 32'(src_o), 32'(tbl[i].exp_src));
                chk($sformatf("vec%0d_data_o", i), 32'(data_o), 32'(tbl[i].exp_data));
            end
            @(negedge clk);
        end

        // Random traffic against a scoreboard and an independent round-robin pointer.
        v_i     = '0;
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        begin
            int unsigned last;
            last = N - 1;
            for (int unsigned cyc = 0; cyc < 10000; cyc++) begin
                int unsigned qs;
                int unsigned s;
                bit          found;
                logic [N-1:0] exp_rdy;
                word_t        w;
                v_i     = N'($urandom);
                ready_i = ($urandom_range(0, 3) != 0);
                for (int unsigned k = 0; k < N; k++) begin
                    data_i[k*W +: W] = W'($urandom);
                end
                #1;
                qs = sb_q.size();
                exp_rdy = '0;
                found   = 1'b0;
                s       = last;
                if (qs < 2) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        s = (s + 1) % N;
                        if (!found && v_i[s]) begin
                            found      = 1'b1;
                            exp_rdy[s] = 1'b1;
                            w.src      = 3'(s);
                            w.data     = data_i[s*W +: W];
                        end
                    end
                end
                chk("rand_ready_o", 32'(ready_o), 32'(exp_rdy));
                chk("rand_v_o", 32'(v_o), 32'(qs != 0));
                if (qs != 0) begin
                    chk("rand_src_o", 32'(src_o), 32'(sb_q[0].src));
                    chk("rand_data_o", 32'(data_o), 32'(sb_q[0].data));
                    if (ready_i) begin
                        void'(sb_q.pop_front());
                    end
                end
                if (found) begin
                    sb_q.push_back(w);
                    last = 32'(w.src);
                end
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
